// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the transmit and receive sides.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic UART_IDLE_LVL = 1'b1;
   localparam int   UART_DATA_W   = 8;
   localparam int   UART_BAUD_DIV = 434;

endpackage

// File: rtl/uart_tx_engine_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = UART_BAUD_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   output logic bit_end
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign bit_end = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (reload || bit_end) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered 8N1 serial transmitter with sticky overflow.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int DATA_W     = UART_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int BAUD_DIV   = UART_BAUD_DIV
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_strobe,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          ovf_clr,
   output logic                          tx,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   tx_state_t state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]  idx_q, idx_d;
   logic              tx_q, tx_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              pop;
   logic              push;
   logic              drop;
   logic              full;
   logic              empty;
   logic              bit_end;
   logic              reload;
   logic [DATA_W-1:0] head;

   assign full  = (cnt_q == DEPTH_C);
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // Counter restarts on every state change and is held at zero while idle.
   assign reload = (state_q == IDLE) || (state_d != state_q);

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .reload  (reload),
      .bit_end (bit_end)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d   = idx_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef UART_TX_PARITY_EN
      if (pop) begin
         par_d = ^head;
      end
`endif
      // Line level follows the state being entered so tx stays a clean flop.
      unique case (state_d)
         START:   tx_d = ~UART_IDLE_LVL;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = UART_IDLE_LVL;
      endcase
   end

   always_comb begin
      push     = wr_strobe && (!full || pop);
      drop     = wr_strobe && full && !pop;
      mem_d    = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      ovf_d    = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         tx_q     <= UART_IDLE_LVL;
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         tx_q     <= tx_d;
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign tx         = tx_q;
   assign tx_busy    = (state_q != IDLE);
   assign tx_done    = (state_q == STOP) && bit_end;
   assign fifo_full  = full;
   assign fifo_empty = empty;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with BAUD_DIV=4, FIFO_DEPTH=4.
// Frame table holds hand-computed line patterns (bit 0 sent first).
module tb_uart_tx_engine;

   localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk;
   logic       rst_n;
   logic       wr_strobe;
   logic [7:0] wr_data;
   logic       ovf_clr;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;
   logic       fifo_full;
   logic       fifo_empty;
   logic [2:0] fifo_count;
   logic       overflow;

   uart_tx_engine #(
      .DATA_W     (8),
      .FIFO_DEPTH (4),
      .BAUD_DIV   (BD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_strobe  (wr_strobe),
      .wr_data    (wr_data),
      .ovf_clr    (ovf_clr),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;
      logic       par;
   } vec_t;

   vec_t tbl[8];
   int   nvec = 0;
   int   nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      wr_strobe = 1'b0;
      ovf_clr   = 1'b0;
   endtask

   task automatic strobe(input logic [7:0] d);
      wr_strobe = 1'b1;
      wr_data   = d;
   endtask

   function automatic logic [10:0] mkexp(input vec_t v);
`ifdef UART_TX_PARITY_EN
      return {1'b1, v.par, v.frame[8:0]};
`else
      return {1'b0, v.frame};
`endif
   endfunction

   // Entered one step after the start bit is driven; leaves on the next frame boundary.
   task automatic frame(input logic [10:0] exp, input string nm);
      logic [BD-1:0] samp;
      logic          last_dn;
      logic          extra_dn;
      extra_dn = 1'b0;
      last_dn  = 1'b0;
      for (int i = 0; i < NB; i++) begin
         for (int c = 0; c < BD; c++) begin
            samp[c] = tx;
            if (i == NB - 1 && c == BD - 1) last_dn = tx_done;
            else if (tx_done) extra_dn = 1'b1;
            step();
         end
         chk($sformatf("%s_bit%0d", nm, i), 32'(samp), {BD{exp[i]}});
      end
      chk({nm, "_done"}, 32'({extra_dn, last_dn}), 32'(2'b01));
   endtask

   task automatic drain(input string nm, input int want);
      int k;
      int dn;
      k  = 0;
      dn = 0;
      while (tx_busy && k < 400) begin
         if (tx_done) dn++;
         step();
         k++;
      end
      chk({nm, "_timeout"}, 32'(k < 400), 32'(1));
      chk({nm, "_dones"}, 32'(dn), 32'(want));
   endtask

   initial begin
      int k;
      logic bad;
      tbl[0] = '{8'hA5, 10'h34A, 1'b0};
      tbl[1] = '{8'h01, 10'h202, 1'b1};
      tbl[2] = '{8'h3C, 10'h278, 1'b0};
      tbl[3] = '{8'hFF, 10'h3FE, 1'b0};
      tbl[4] = '{8'h00, 10'h200, 1'b0};
      tbl[5] = '{8'h80, 10'h300, 1'b1};
      tbl[6] = '{8'h07, 10'h20E, 1'b1};
      tbl[7] = '{8'h03, 10'h206, 1'b0};

      rst_n     = 1'b0;
      wr_strobe = 1'b0;
      wr_data   = 8'h00;
      ovf_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", 32'(tx), 32'(1));
      chk("rst_busy", 32'(tx_busy), 32'(0));
      chk("rst_done", 32'(tx_done), 32'(0));
      chk("rst_full", 32'(fifo_full), 32'(0));
      chk("rst_empty", 32'(fifo_empty), 32'(1));
      chk("rst_count", 32'(fifo_count), 32'(0));
      chk("rst_ovf", 32'(overflow), 32'(0));
      rst_n = 1'b1;
      step();

      for (int v = 0; v < 8; v++) begin
         strobe(tbl[v].data);
         step();
         chk($sformatf("v%0d_count", v), 32'(fifo_count), 32'(1));
         chk($sformatf("v%0d_idle_tx", v), 32'(tx), 32'(1));
         wr_data = ~tbl[v].data;
         step();
         chk($sformatf("v%0d_busy", v), 32'(tx_busy), 32'(1));
         frame(mkexp(tbl[v]), $sformatf("v%0d", v));
         chk($sformatf("v%0d_end_busy", v), 32'(tx_busy), 32'(0));
         chk($sformatf("v%0d_end_empty", v), 32'(fifo_empty), 32'(1));
         step();
      end

      strobe(8'h01);
      step();
      strobe(8'h02);
      step();
      strobe(8'h03);
      frame(mkexp('{8'h01, 10'h202, 1'b1}), "b2b1");
      frame(mkexp('{8'h02, 10'h204, 1'b1}), "b2b2");
      frame(mkexp('{8'h03, 10'h206, 1'b0}), "b2b3");
      chk("b2b_empty", 32'(fifo_empty), 32'(1));
      chk("b2b_busy", 32'(tx_busy), 32'(0));
      step();

      for (int i = 0; i < 6; i++) begin
         strobe(8'h10 + 8'(i));
         step();
      end
      chk("ovf_full", 32'(fifo_full), 32'(1));
      chk("ovf_count", 32'(fifo_count), 32'(4));
      chk("ovf_set", 32'(overflow), 32'(1));
      repeat (3) step();
      chk("ovf_held", 32'(overflow), 32'(1));
      ovf_clr = 1'b1;
      step();
      chk("ovf_clr", 32'(overflow), 32'(0));
      drain("ovf", 5);
      chk("ovf_empty", 32'(fifo_empty), 32'(1));

      step();
      strobe(8'hFF);
      step();
      strobe(8'h00);
      step();
      repeat (17) step();
      chk("rst_mid_busy", 32'(tx_busy), 32'(1));
      chk("rst_mid_count", 32'(fifo_count), 32'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_tx", 32'(tx), 32'(1));
      chk("rst_mid_busy0", 32'(tx_busy), 32'(0));
      chk("rst_mid_count0", 32'(fifo_count), 32'(0));
      chk("rst_mid_empty", 32'(fifo_empty), 32'(1));
      @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
         step();
      end
      chk("rst_mid_quiet", 32'(bad), 32'(0));

      for (int i = 0; i < 5; i++) begin
         strobe(8'h21 + 8'(i));
         step();
      end
      chk("fp_full", 32'(fifo_full), 32'(1));
      k = 0;
      while (tx_done !== 1'b1 && k < 100) begin
         step();
         k++;
      end
      chk("fp_wait", 32'(k < 100), 32'(1));
      chk("fp_full_at_stop", 32'(fifo_count), 32'(4));
      strobe(8'h26);
      step();
      chk("fp_ovf", 32'(overflow), 32'(0));
      chk("fp_count", 32'(fifo_count), 32'(4));
      chk("fp_busy", 32'(tx_busy), 32'(1));
      drain("fp", 5);
      chk("fp_ovf_end", 32'(overflow), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
